axi_id_width_converter: RTL and testbench
=========================================

Name: axi_id_width_converter

Overview:
- AXI4+ATOP ID-width converter between an upstream slave port (SLV_ID_W-bit IDs) and a downstream master port (MST_ID_W-bit IDs).
- Widening or equal width: IDs are zero-extended on requests and truncated on responses.
- Narrowing: slave IDs are remapped onto a small table of master IDs, and the original IDs are restored on B/R.
- Sits between an interconnect crossbar and a slave that has a different ID width.

Parameters:
- SLV_ID_W, 4: slave-port ID width (>=1)
- MST_ID_W, 2: master-port ID width (>=1)
- MAX_UNIQ_IDS, 4: remap-table entries per direction, <= 2^MST_ID_W; used only when narrowing
- MAX_TXNS_PER_ID, 4: outstanding transactions allowed per table entry
- ADDR_W, 32: address width
- DATA_W, 32: data width
- USER_W, 4: user width on all channels

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- slv_aw_*/slv_ar_*  in  full AXI4+ATOP AW/AR fields, id SLV_ID_W; upstream requests
- slv_aw_ready/slv_ar_ready  out  1  request accept
- slv_w_*  in  data/strb/last/user/valid; slv_w_ready out
- slv_b_*/slv_r_*  out  id SLV_ID_W + resp/data/last/user/valid; slv_b_ready/slv_r_ready in
- mst_aw_*/mst_ar_*/mst_w_*  out  same fields as slave side, id MST_ID_W; *_ready in
- mst_b_*/mst_r_*  in  id MST_ID_W; mst_b_ready/mst_r_ready out
- Interface signal: reset rst_n, asynchronous, active-high; clock clk.

Behaviour:
- Reset: while rst_n asserted, remap tables are cleared and all valid/ready outputs are driven 0.
- All non-ID fields pass through combinationally. Zero latency, no registers on the data path.
- W channel is a pure passthrough.
- Passthrough mode (MST_ID_W >= SLV_ID_W):
  - mst id = zero-extended slv id.
  - slv B/R id = low SLV_ID_W bits of mst id.
  - No state.
- Remap mode (MST_ID_W < SLV_ID_W):
  - Separate write table (AW/B) and read table (AR/R).
  - Each entry i holds: busy, slv_id, cnt (0..MAX_TXNS_PER_ID). Master ID = i.
- Request acceptance (AW/AR):
  - Slave ID hits a busy entry with cnt < MAX: use that entry.
  - Hit with cnt == MAX: stall.
  - Miss: use the lowest free entry. No free entry: stall.
  - Stall means mst valid = 0 and slv ready = 0.
  - Otherwise mst valid = slv valid and slv ready = mst ready. Valid never depends on ready.
  - On handshake: entry becomes busy, slv_id is stored, cnt += 1.
- Responses:
  - B id = wtable[mst_b_id].slv_id; each B handshake decrements cnt.
  - R id = rtable[mst_r_id].slv_id; decrement only on an R handshake with last = 1.
  - cnt reaching 0 frees the entry.
- Simultaneous allocation and free: allocation uses the pre-cycle state; the counter nets correctly (+1 and -1 gives unchanged).
- ATOP on AW with atop[5] = 1:
  - Always allocates a fresh entry at the lowest index free in both tables.
  - Handshake marks both entries busy with cnt = 1.
  - Stalls if no such index exists.
- ATOPs with atop[5] = 0 are treated as normal writes.
- Responses with an ID whose entry is not busy are a protocol violation. Behaviour is undefined; an assertion flags it.
- Ordering is preserved per slave ID: same slave ID always maps to the same master ID while outstanding.

Optional Feature:
- AXI_IWC_REQ_REG_EN defined: AW and AR master outputs go through a spill register (full throughput, +1 cycle latency).
  - Table update happens on the slave-side handshake.
  - Register contents are cleared on reset.
- Not defined: combinational path as above.

Test Plan:
- Passthrough, SLV_ID_W=2, MST_ID_W=4: AR id 3 -> mst_ar_id 4'h3; R id 4'h3 -> slv_r_id 2'h3, data unchanged.
- Remap, SLV_ID_W=4, MST_ID_W=2: AW ids 0xA, 0x5 -> mst ids 0, 1. B id 1 -> slv_b_id 0x5, entry 1 freed.
- Same ID 0xA sent 4 times with no B: 5th AW stalls (slv_aw_ready = 0) until one B returns, then is accepted with mst id 0.
- Four distinct read IDs outstanding: 5th distinct AR stalls. R with last = 0 frees nothing; R last on id 2 frees entry 2, and the new AR gets mst id 2.
- ATOP atop = 6'b100000 with write entry 0 and read entry 0 busy: allocates index 1. B and R both return id 1 restored to the original slave ID.
- Assert rst_n mid-burst with 3 outstanding: all valids and readies go 0, tables empty; after release, the first AW gets mst id 0.

Source files
------------

// File: rtl/axi_id_width_converter_if.sv
// AXI4+ATOP bus bundle for the ID-width converter.
// ID_W sets the ID width of this side; master drives requests.
interface axi_id_width_converter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USER_W = 4
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [5:0]          aw_atop;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        output aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        output aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        output ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        input aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        input aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        input ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input r_ready
    );
endinterface

// File: rtl/axi_id_width_converter.sv
// AXI4+ATOP ID-width converter: zero-extends or remaps IDs, restores them on B/R.
// rst_n is active-high async; AXI_IWC_REQ_REG_EN adds a register stage on AW/AR.
module axi_id_width_converter #(
    parameter int SLV_ID_W        = 4,
    parameter int MST_ID_W        = 2,
    parameter int MAX_UNIQ_IDS    = 4,
    parameter int MAX_TXNS_PER_ID = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int USER_W          = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    axi_id_width_converter_if.slave  slv,
    axi_id_width_converter_if.master mst
);
    localparam int AWW = MST_ID_W + ADDR_W + 35 + USER_W;
    localparam int ARW = MST_ID_W + ADDR_W + 29 + USER_W;
    localparam int WW  = DATA_W + DATA_W / 8 + USER_W + 1;

    logic                run;
    logic                aw_ok, ar_ok;
    logic                aw_rdy, ar_rdy;
    logic                aw_v, ar_v;
    logic [MST_ID_W-1:0] aw_mid, ar_mid;
    logic [AWW-1:0]      aw_d, aw_p;
    logic [ARW-1:0]      ar_d, ar_p;
    logic [WW-1:0]       w_p;

    assign run = !rst_n;

    assign aw_v = run & slv.aw_valid & aw_ok;
    assign ar_v = run & slv.ar_valid & ar_ok;
    assign slv.aw_ready = run & aw_ok & aw_rdy;
    assign slv.ar_ready = run & ar_ok & ar_rdy;

    assign aw_d = {aw_mid, slv.aw_addr, slv.aw_len, slv.aw_size,
                   slv.aw_burst, slv.aw_lock, slv.aw_cache, slv.aw_prot,
                   slv.aw_qos, slv.aw_region, slv.aw_atop, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size,
            mst.aw_burst, mst.aw_lock, mst.aw_cache, mst.aw_prot,
            mst.aw_qos, mst.aw_region, mst.aw_atop, mst.aw_user} = aw_p;

    assign ar_d = {ar_mid, slv.ar_addr, slv.ar_len, slv.ar_size,
                   slv.ar_burst, slv.ar_lock, slv.ar_cache, slv.ar_prot,
                   slv.ar_qos, slv.ar_region, slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size,
            mst.ar_burst, mst.ar_lock, mst.ar_cache, mst.ar_prot,
            mst.ar_qos, mst.ar_region, mst.ar_user} = ar_p;

    assign w_p = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_p;
    assign mst.w_valid = run & slv.w_valid;
    assign slv.w_ready = run & mst.w_ready;

    assign slv.b_resp  = mst.b_resp;
    assign slv.b_user  = mst.b_user;
    assign slv.b_valid = run & mst.b_valid;
    assign mst.b_ready = run & slv.b_ready;

    assign slv.r_data  = mst.r_data;
    assign slv.r_resp  = mst.r_resp;
    assign slv.r_last  = mst.r_last;
    assign slv.r_user  = mst.r_user;
    assign slv.r_valid = run & mst.r_valid;
    assign mst.r_ready = run & slv.r_ready;

`ifdef AXI_IWC_REQ_REG_EN
    logic           aw_q_v, ar_q_v;
    logic [AWW-1:0] aw_q;
    logic [ARW-1:0] ar_q;

    assign aw_rdy = !aw_q_v || mst.aw_ready;
    assign ar_rdy = !ar_q_v || mst.ar_ready;
    assign mst.aw_valid = run & aw_q_v;
    assign mst.ar_valid = run & ar_q_v;
    assign aw_p = aw_q;
    assign ar_p = ar_q;

    // request stage: reload whenever empty or draining downstream
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            aw_q_v <= 1'b0;
            aw_q   <= '0;
            ar_q_v <= 1'b0;
            ar_q   <= '0;
        end else begin
            if (aw_rdy) begin
                aw_q_v <= aw_v;
                aw_q   <= aw_d;
            end
            if (ar_rdy) begin
                ar_q_v <= ar_v;
                ar_q   <= ar_d;
            end
        end
    end
`else
    assign aw_rdy = mst.aw_ready;
    assign ar_rdy = mst.ar_ready;
    assign mst.aw_valid = aw_v;
    assign mst.ar_valid = ar_v;
    assign aw_p = aw_d;
    assign ar_p = ar_d;
`endif

    if (MST_ID_W >= SLV_ID_W) begin : g_pass
        assign aw_ok = 1'b1;
        assign ar_ok = 1'b1;
        assign aw_mid = MST_ID_W'(slv.aw_id);
        assign ar_mid = MST_ID_W'(slv.ar_id);
        assign slv.b_id = mst.b_id[SLV_ID_W-1:0];
        assign slv.r_id = mst.r_id[SLV_ID_W-1:0];
    end else begin : g_remap
        localparam int N  = MAX_UNIQ_IDS;
        localparam int CW = $clog2(MAX_TXNS_PER_ID + 1);
        typedef logic [MST_ID_W-1:0] idx_t;

        logic [SLV_ID_W-1:0] wid_q  [N];
        logic [SLV_ID_W-1:0] rid_q  [N];
        logic [CW-1:0]       wcnt_q [N];
        logic [CW-1:0]       rcnt_q [N];
        logic [N-1:0]        winc, wdec, rinc, rdec, ratop;
        logic                aw_hit, aw_free, aw_fresh;
        logic                ar_hit, ar_free;
        idx_t                aw_h, aw_f, aw_b, ar_h, ar_f;
        logic [CW-1:0]       aw_hc, ar_hc;
        logic                atop, ar_req;
        logic                aw_hs, ar_hs, b_hs, r_hs, r_done;
        logic                b_live, r_live;

        assign atop   = slv.aw_atop[5];
        assign ar_req = slv.ar_valid & ar_ok;
        assign aw_hs  = slv.aw_valid & slv.aw_ready;
        assign ar_hs  = slv.ar_valid & slv.ar_ready;
        assign b_hs   = slv.b_valid & slv.b_ready;
        assign r_hs   = slv.r_valid & slv.r_ready;
        assign r_done = r_hs & slv.r_last;

        // AR lookup: live entry for this ID, else lowest free entry
        always_comb begin
            ar_hit  = 1'b0;
            ar_free = 1'b0;
            ar_h    = '0;
            ar_f    = '0;
            ar_hc   = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (rcnt_q[i] != '0 && rid_q[i] == slv.ar_id) begin
                    ar_hit = 1'b1;
                    ar_h   = idx_t'(i);
                    ar_hc  = rcnt_q[i];
                end
                if (rcnt_q[i] == '0) begin
                    ar_free = 1'b1;
                    ar_f    = idx_t'(i);
                end
            end
            ar_mid = ar_hit ? ar_h : ar_f;
            ar_ok  = ar_hit ? (ar_hc < CW'(MAX_TXNS_PER_ID)) : ar_free;
        end

        // AW lookup; atomics need an index idle in both tables and
        // must not collide with the index a pending AR is taking
        always_comb begin
            aw_hit   = 1'b0;
            aw_free  = 1'b0;
            aw_fresh = 1'b0;
            aw_h     = '0;
            aw_f     = '0;
            aw_b     = '0;
            aw_hc    = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (wcnt_q[i] != '0 && wid_q[i] == slv.aw_id) begin
                    aw_hit = 1'b1;
                    aw_h   = idx_t'(i);
                    aw_hc  = wcnt_q[i];
                end
                if (wcnt_q[i] == '0) begin
                    aw_free = 1'b1;
                    aw_f    = idx_t'(i);
                end
                if (wcnt_q[i] == '0 && rcnt_q[i] == '0 &&
                    !(ar_req && ar_mid == idx_t'(i))) begin
                    aw_fresh = 1'b1;
                    aw_b     = idx_t'(i);
                end
            end
            if (atop) begin
                aw_mid = aw_b;
                aw_ok  = aw_fresh;
            end else if (aw_hit) begin
                aw_mid = aw_h;
                aw_ok  = aw_hc < CW'(MAX_TXNS_PER_ID);
            end else begin
                aw_mid = aw_f;
                aw_ok  = aw_free;
            end
        end

        // restore slave IDs on responses
        always_comb begin
            slv.b_id = '0;
            slv.r_id = '0;
            b_live   = 1'b0;
            r_live   = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (mst.b_id == idx_t'(i)) begin
                    slv.b_id = wid_q[i];
                    b_live   = wcnt_q[i] != '0;
                end
                if (mst.r_id == idx_t'(i)) begin
                    slv.r_id = rid_q[i];
                    r_live   = rcnt_q[i] != '0;
                end
            end
        end

        // per-entry allocate/retire strobes
        always_comb begin
            for (int i = 0; i < N; i++) begin
                winc[i]  = aw_hs && aw_mid == idx_t'(i);
                wdec[i]  = b_hs && mst.b_id == idx_t'(i);
                ratop[i] = winc[i] && atop;
                rinc[i]  = (ar_hs && ar_mid == idx_t'(i)) || ratop[i];
                rdec[i]  = r_done && mst.r_id == idx_t'(i);
            end
        end

        // remap tables; count of zero means the entry is free
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    wid_q[i]  <= '0;
                    rid_q[i]  <= '0;
                    wcnt_q[i] <= '0;
                    rcnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (winc[i]) wid_q[i] <= slv.aw_id;
                    if (rinc[i]) rid_q[i] <= ratop[i] ? slv.aw_id : slv.ar_id;
                    wcnt_q[i] <= wcnt_q[i] + CW'(winc[i]) - CW'(wdec[i]);
                    rcnt_q[i] <= rcnt_q[i] + CW'(rinc[i]) - CW'(rdec[i]);
                end
            end
        end

`ifndef SYNTHESIS
        // a response on an idle entry is a protocol violation
        always @(posedge clk) begin
            if (!rst_n) begin
                assert (!b_hs || b_live)
                    else $error("B id %0d not outstanding", mst.b_id);
                assert (!r_hs || r_live)
                    else $error("R id %0d not outstanding", mst.r_id);
            end
        end
`endif
    end
endmodule

// File: tb/tb_axi_id_width_converter.sv
// Directed bench for axi_id_width_converter: one passthrough and one
// remapping instance, hand-computed expectations, immediate assertions.
`define SLV_IDLE(x) \
    x.aw_id = '0; x.aw_addr = '0; x.aw_len = '0; x.aw_size = '0; \
    x.aw_burst = '0; x.aw_lock = 1'b0; x.aw_cache = '0; x.aw_prot = '0; \
    x.aw_qos = '0; x.aw_region = '0; x.aw_atop = '0; x.aw_user = '0; \
    x.aw_valid = 1'b0; x.w_data = '0; x.w_strb = '0; x.w_last = 1'b0; \
    x.w_user = '0; x.w_valid = 1'b0; x.b_ready = 1'b0; \
    x.ar_id = '0; x.ar_addr = '0; x.ar_len = '0; x.ar_size = '0; \
    x.ar_burst = '0; x.ar_lock = 1'b0; x.ar_cache = '0; x.ar_prot = '0; \
    x.ar_qos = '0; x.ar_region = '0; x.ar_user = '0; \
    x.ar_valid = 1'b0; x.r_ready = 1'b0;

`define MST_IDLE(x) \
    x.aw_ready = 1'b0; x.w_ready = 1'b0; x.ar_ready = 1'b0; \
    x.b_id = '0; x.b_resp = '0; x.b_user = '0; x.b_valid = 1'b0; \
    x.r_id = '0; x.r_data = '0; x.r_resp = '0; x.r_last = 1'b0; \
    x.r_user = '0; x.r_valid = 1'b0;

module tb_axi_id_width_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_id_width_converter_if #(.ID_W(2)) ps ();
    axi_id_width_converter_if #(.ID_W(4)) pm ();
    axi_id_width_converter_if #(.ID_W(4)) rs ();
    axi_id_width_converter_if #(.ID_W(2)) rm ();

    axi_id_width_converter #(.SLV_ID_W(2), .MST_ID_W(4)) u_pt (
        .clk(clk), .rst_n(rst_n), .slv(ps), .mst(pm)
    );
    axi_id_width_converter #(.SLV_ID_W(4), .MST_ID_W(2)) u_rm (
        .clk(clk), .rst_n(rst_n), .slv(rs), .mst(rm)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        `SLV_IDLE(ps)
        `SLV_IDLE(rs)
        `MST_IDLE(pm)
        `MST_IDLE(rm)
        pm.ar_ready = 1'b1;
        rm.aw_ready = 1'b1;
        rm.ar_ready = 1'b1;
        rm.w_ready = 1'b1;

        // reset held: every valid/ready output must be low
        rs.aw_valid = 1'b1;
        rs.w_valid = 1'b1;
        rm.b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mst_aw_valid", rm.aw_valid, 0);
        chk("rst_slv_aw_ready", rs.aw_ready, 0);
        chk("rst_slv_b_valid", rs.b_valid, 0);
        chk("rst_mst_w_valid", rm.w_valid, 0);
        chk("rst_slv_w_ready", rs.w_ready, 0);
        rs.aw_valid = 1'b0;
        rs.w_valid = 1'b0;
        rm.b_valid = 1'b0;
        #2 rst_n = 1'b0;
        step();

        // passthrough widening
        ps.ar_id = 2'h3;
        ps.ar_addr = 32'h0000_1234;
        ps.ar_valid = 1'b1;
        settle();
        chk("pt_ar_id", pm.ar_id, 4'h3);
        chk("pt_ar_addr", pm.ar_addr, 32'h0000_1234);
        chk("pt_ar_ready", ps.ar_ready, 1);
        step();
        ps.ar_valid = 1'b0;
        pm.r_id = 4'h3;
        pm.r_data = 32'hDEAD_BEEF;
        pm.r_last = 1'b1;
        pm.r_valid = 1'b1;
        ps.r_ready = 1'b1;
        settle();
        chk("pt_r_id", ps.r_id, 2'h3);
        chk("pt_r_data", ps.r_data, 32'hDEAD_BEEF);
        chk("pt_r_valid", ps.r_valid, 1);
        step();
        pm.r_valid = 1'b0;

        // remap: two writes, then free entry 1
        rs.aw_id = 4'hA;
        rs.aw_valid = 1'b1;
        settle();
        chk("rm_aw_a_id", rm.aw_id, 0);
        chk("rm_aw_a_ready", rs.aw_ready, 1);
        step();
        rs.aw_id = 4'h5;
        settle();
        chk("rm_aw_5_id", rm.aw_id, 1);
        step();
        rs.aw_valid = 1'b0;
        rm.b_id = 2'd1;
        rm.b_valid = 1'b1;
        rs.b_ready = 1'b1;
        settle();
        chk("rm_b1_id", rs.b_id, 4'h5);
        step();
        rm.b_valid = 1'b0;
        rs.aw_id = 4'h7;
        rs.aw_valid = 1'b1;
        settle();
        chk("rm_entry1_freed", rm.aw_id, 1);
        rs.aw_valid = 1'b0;
        step();

        // same ID up to the per-entry limit, then stall
        rs.aw_id = 4'hA;
        rs.aw_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("rm_same_id", rm.aw_id, 0);
            step();
        end
        settle();
        chk("rm_full_ready", rs.aw_ready, 0);
        chk("rm_full_valid", rm.aw_valid, 0);
        rm.b_id = 2'd0;
        rm.b_valid = 1'b1;
        settle();
        chk("rm_b0_id", rs.b_id, 4'hA);
        chk("rm_full_same_cycle", rs.aw_ready, 0);
        step();
        rm.b_valid = 1'b0;
        settle();
        chk("rm_unstall_ready", rs.aw_ready, 1);
        chk("rm_unstall_id", rm.aw_id, 0);
        step();
        rs.aw_valid = 1'b0;

        // reads: fill the table, stall, free via last beat
        rs.ar_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rs.ar_id = 4'(k + 1);
            settle();
            chk("rm_ar_id", rm.ar_id, 64'(k));
            step();
        end
        rs.ar_id = 4'h9;
        settle();
        chk("rm_ar_full_ready", rs.ar_ready, 0);
        chk("rm_ar_full_valid", rm.ar_valid, 0);
        rm.r_id = 2'd2;
        rm.r_data = 32'h55AA_00FF;
        rm.r_last = 1'b0;
        rm.r_valid = 1'b1;
        rs.r_ready = 1'b1;
        settle();
        chk("rm_r2_id", rs.r_id, 4'h3);
        chk("rm_r2_data", rs.r_data, 32'h55AA_00FF);
        step();
        settle();
        chk("rm_r_nolast_stall", rs.ar_ready, 0);
        rm.r_last = 1'b1;
        step();
        rm.r_valid = 1'b0;
        settle();
        chk("rm_ar_reuse_ready", rs.ar_ready, 1);
        chk("rm_ar_reuse_id", rm.ar_id, 2);
        step();
        rs.ar_valid = 1'b0;

        // atomic: needs index 1 free in both tables
        rm.r_id = 2'd1;
        rm.r_last = 1'b1;
        rm.r_valid = 1'b1;
        settle();
        chk("rm_r1_id", rs.r_id, 4'h2);
        step();
        rm.r_valid = 1'b0;
        rs.aw_id = 4'hC;
        rs.aw_atop = 6'b100000;
        rs.aw_valid = 1'b1;
        settle();
        chk("rm_atop_id", rm.aw_id, 1);
        chk("rm_atop_ready", rs.aw_ready, 1);
        chk("rm_atop_field", rm.aw_atop, 6'b100000);
        step();
        rs.aw_valid = 1'b0;
        rs.aw_atop = 6'b000000;
        rm.b_id = 2'd1;
        rm.b_valid = 1'b1;
        rm.r_id = 2'd1;
        rm.r_last = 1'b1;
        rm.r_valid = 1'b1;
        settle();
        chk("rm_atop_b_id", rs.b_id, 4'hC);
        chk("rm_atop_r_id", rs.r_id, 4'hC);
        step();
        rm.b_valid = 1'b0;
        rm.r_valid = 1'b0;

        // reset mid-traffic with entries outstanding
        rs.aw_id = 4'h3;
        rs.aw_valid = 1'b1;
        rs.ar_id = 4'hB;
        rs.ar_valid = 1'b1;
        rm.b_id = 2'd0;
        rm.b_valid = 1'b1;
        settle();
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_aw_valid", rm.aw_valid, 0);
        chk("mid_rst_ar_valid", rm.ar_valid, 0);
        chk("mid_rst_ar_ready", rs.ar_ready, 0);
        chk("mid_rst_b_valid", rs.b_valid, 0);
        chk("mid_rst_b_ready", rm.b_ready, 0);
        rm.b_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("post_rst_aw_id", rm.aw_id, 0);
        chk("post_rst_aw_ready", rs.aw_ready, 1);
        chk("post_rst_ar_id", rm.ar_id, 0);
        rs.aw_valid = 1'b0;
        rs.ar_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
